// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID to EX pipeline register with two-entry skid buffer, flush and stall/flush counters
module id_ex_pipe #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] A_0,
  input  logic [WORD_WIDTH-1:0] B_0,
  input  logic [31:0]           IR_0,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] A_1,
  output logic [WORD_WIDTH-1:0] B_1,
  output logic [31:0]           IR_1,
  output logic [5:0]            Out31_26_1,
  output logic [4:0]            Out25_21_1,
  output logic [4:0]            Out20_16_1,
  output logic [4:0]            Out15_11_1,
  output logic [4:0]            Out10_6_1,
  output logic [5:0]            Out5_0_1,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WORD_WIDTH-1:0] skid_a;
  logic [WORD_WIDTH-1:0] skid_b;
  logic [31:0]           skid_ir;

  logic accept;
  logic take;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  // Handshake qualifiers; flush suppresses both sides in the cycle it is raised.
  assign accept = in_valid & in_ready & ~flush;
  assign take   = out_valid & out_ready & ~flush;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush drops everything held back to EMPTY.
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) state_next = ONE;
        ONE: begin
          if (accept && !take)      state_next = FULL;
          else if (!accept && take) state_next = EMPTY;
        end
        FULL:    if (take) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Outputs and data-move enables, decoded from the state register only so
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    out_valid      = 1'b0;
    in_ready       = 1'b1;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        load_main_in = accept;
      end
      ONE: begin
        out_valid    = 1'b1;
        load_main_in = accept & take;
        load_skid    = accept & ~take;
      end
      FULL: begin
        out_valid      = 1'b1;
        in_ready       = 1'b0;
        load_main_skid = take;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
    endcase
  end

  // Main entry: loaded from decode or promoted from the skid slot; stale data is left on flush.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      A_1  <= '0;
      B_1  <= '0;
      IR_1 <= '0;
    end else if (load_main_in) begin
      A_1  <= A_0;
      B_1  <= B_0;
      IR_1 <= IR_0;
    end else if (load_main_skid) begin
      A_1  <= skid_a;
      B_1  <= skid_b;
      IR_1 <= skid_ir;
    end
  end

  // Skid entry: captures the input that arrives while the main entry is stalled.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      skid_a  <= '0;
      skid_b  <= '0;
      skid_ir <= '0;
    end else if (load_skid) begin
      skid_a  <= A_0;
      skid_b  <= B_0;
      skid_ir <= IR_0;
    end
  end

  // Saturating statistics: stalled cycles and flushes that discarded a live entry.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && (state != EMPTY) && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign Out31_26_1 = IR_1[31:26];
  assign Out25_21_1 = IR_1[25:21];
  assign Out20_16_1 = IR_1[20:16];
  assign Out15_11_1 = IR_1[15:11];
  assign Out10_6_1  = IR_1[10:6];
  assign Out5_0_1   = IR_1[5:0];

endmodule
